// File: rtl/vending_controller_if.sv
// Signal bundle between the vending sequencer and its surroundings:
// the coin path, the keypad, the dispenser and the coin-return actuator.
interface vending_controller_if #(
  parameter int CREDIT_W = 8
);
  logic                coin_valid;
  logic [3:0]          amount;
  logic                select_valid;
  logic [1:0]          product_id;
  logic                cancel;
  logic                dispense_ack;
  logic                change_ack;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                insufficient;
  logic                dispense_valid;
  logic [1:0]          dispense_id;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic                busy;

  // Both output handshakes use valid/ready semantics: the valid is held and its
  // payload kept stable until the cycle the ack is high; an ack without a
  // valid does nothing.
  modport master (
    output coin_valid, amount, select_valid, product_id, cancel,
           dispense_ack, change_ack,
    input  credit, coin_reject, insufficient, dispense_valid, dispense_id,
           change_valid, change_amount, busy
  );

  modport slave (
    input  coin_valid, amount, select_valid, product_id, cancel,
           dispense_ack, change_ack,
    output credit, coin_reject, insufficient, dispense_valid, dispense_id,
           change_valid, change_amount, busy
  );
endinterface

// File: rtl/vending_controller.sv
// Vending machine sequencer: accumulates coin credit, checks a selection
// against the price table, then runs the dispense and change handshakes.
module vending_controller #(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 60,
  parameter int PRICE0     = 5,
  parameter int PRICE1     = 8,
  parameter int PRICE2     = 12,
  parameter int PRICE3     = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  vending_controller_if.slave  bus,
  output logic [2:0]           o_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_CHECK    = 3'd2,
    S_DISPENSE = 3'd3,
    S_CHANGE   = 3'd4
  } state_t;

  localparam logic [CREDIT_W:0]   MAX_W = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] P0    = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] P1    = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2    = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] P3    = CREDIT_W'(PRICE3);

  state_t              r_state, w_state;
  logic [CREDIT_W-1:0] r_credit, w_credit;
  logic [1:0]          r_prod, w_prod;
  logic                r_coin_reject, w_coin_reject;
  logic                r_insufficient, w_insufficient;
  logic                r_dv, w_dv;
  logic [1:0]          r_did, w_did;
  logic                r_cv, w_cv;
  logic [CREDIT_W-1:0] r_camt, w_camt;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_price;

  // One bit wider than the credit so an oversized coin cannot wrap past the limit.
  assign w_sum = {1'b0, r_credit} + {{(CREDIT_W-3){1'b0}}, bus.amount};

  always_comb begin
    case (r_prod)
      2'd0:    w_price = P0;
      2'd1:    w_price = P1;
      2'd2:    w_price = P2;
      default: w_price = P3;
    endcase
  end

  always_comb begin
    w_state        = r_state;
    w_credit       = r_credit;
    w_prod         = r_prod;
    w_coin_reject  = 1'b0;
    w_insufficient = 1'b0;
    w_dv           = r_dv;
    w_did          = r_did;
    w_cv           = r_cv;
    w_camt         = r_camt;
    case (r_state)
      S_IDLE: begin
        w_insufficient = bus.select_valid;
        if (bus.coin_valid && bus.amount != 4'd0) begin
          w_credit = {{(CREDIT_W-4){1'b0}}, bus.amount};
          w_state  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A coin loses to a simultaneous cancel or selection and is refused.
        if (bus.cancel) begin
          w_coin_reject = bus.coin_valid;
          if (r_credit != '0) begin
            w_camt  = r_credit;
            w_cv    = 1'b1;
            w_state = S_CHANGE;
          end else begin
            w_state = S_IDLE;
          end
        end else if (bus.select_valid) begin
          w_coin_reject = bus.coin_valid;
          w_prod        = bus.product_id;
          w_state       = S_CHECK;
        end else if (bus.coin_valid) begin
          if (w_sum <= MAX_W) w_credit = w_sum[CREDIT_W-1:0];
          else                w_coin_reject = 1'b1;
        end
      end
      S_CHECK: begin
        w_coin_reject = bus.coin_valid;
        if (r_credit >= w_price) begin
          w_credit = r_credit - w_price;
          w_did    = r_prod;
          w_dv     = 1'b1;
          w_state  = S_DISPENSE;
        end else begin
          w_insufficient = 1'b1;
          w_state        = S_COLLECT;
        end
      end
      S_DISPENSE: begin
        w_coin_reject = bus.coin_valid;
        if (bus.dispense_ack) begin
          w_dv = 1'b0;
          if (r_credit != '0) begin
            w_camt  = r_credit;
            w_cv    = 1'b1;
            w_state = S_CHANGE;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        w_coin_reject = bus.coin_valid;
        if (bus.change_ack) begin
          w_cv     = 1'b0;
          w_credit = '0;
          w_camt   = '0;
          w_state  = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_prod         <= 2'd0;
      r_coin_reject  <= 1'b0;
      r_insufficient <= 1'b0;
      r_dv           <= 1'b0;
      r_did          <= 2'd0;
      r_cv           <= 1'b0;
      r_camt         <= '0;
    end else begin
      r_state        <= w_state;
      r_credit       <= w_credit;
      r_prod         <= w_prod;
      r_coin_reject  <= w_coin_reject;
      r_insufficient <= w_insufficient;
      r_dv           <= w_dv;
      r_did          <= w_did;
      r_cv           <= w_cv;
      r_camt         <= w_camt;
    end
  end

  assign bus.credit         = r_credit;
  assign bus.coin_reject    = r_coin_reject;
  assign bus.insufficient   = r_insufficient;
  assign bus.dispense_valid = r_dv;
  assign bus.dispense_id    = r_did;
  assign bus.change_valid   = r_cv;
  assign bus.change_amount  = r_camt;
  assign bus.busy           = (r_state == S_CHECK) || (r_state == S_DISPENSE) ||
                              (r_state == S_CHANGE);
  assign o_state_dbg        = r_state;

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: directed scenarios plus a random
// coin/select loop; dispensed ids and change amounts go through a scoreboard.
module tb_vending_controller;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COLLECT  = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_DISPENSE = 3'd3;
  localparam logic [2:0] ST_CHANGE   = 3'd4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state_dbg;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         price_tab[4] = '{5, 8, 12, 15};
  logic [7:0] exp_disp_q[$];
  logic [7:0] exp_chg_q[$];

  vending_controller_if #(.CREDIT_W(8)) vif();

  vending_controller dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (vif.slave),
    .o_state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset && vif.dispense_valid && vif.dispense_ack) begin
      check("disp_q_nonempty", exp_disp_q.size() != 0, 1);
      if (exp_disp_q.size() != 0) check("dispense_id", vif.dispense_id, exp_disp_q.pop_front());
    end
    if (!reset && vif.change_valid && vif.change_ack) begin
      check("chg_q_nonempty", exp_chg_q.size() != 0, 1);
      if (exp_chg_q.size() != 0) check("change_amount", vif.change_amount, exp_chg_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic c, input logic [3:0] a, input logic s,
                       input logic [1:0] p, input logic x);
    vif.coin_valid   = c;
    vif.amount       = a;
    vif.select_valid = s;
    vif.product_id   = p;
    vif.cancel       = x;
    step();
    vif.coin_valid   = 1'b0;
    vif.amount       = 4'd0;
    vif.select_valid = 1'b0;
    vif.product_id   = 2'd0;
    vif.cancel       = 1'b0;
  endtask

  task automatic coin(input logic [3:0] a);
    drive(1'b1, a, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic select(input logic [1:0] p);
    drive(1'b0, 4'd0, 1'b1, p, 1'b0);
  endtask

  task automatic cancel_req();
    drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic ack_dispense();
    for (int i = 0; i < 8 && !vif.dispense_valid; i++) step();
    check("disp_wait", vif.dispense_valid, 1);
    vif.dispense_ack = 1'b1;
    step();
    vif.dispense_ack = 1'b0;
  endtask

  task automatic ack_change();
    for (int i = 0; i < 8 && !vif.change_valid; i++) step();
    check("chg_wait", vif.change_valid, 1);
    vif.change_ack = 1'b1;
    step();
    vif.change_ack = 1'b0;
  endtask

  task automatic check_idle_clean(input string tag);
    check({tag, "_state"},  state_dbg, ST_IDLE);
    check({tag, "_credit"}, vif.credit, 0);
    check({tag, "_dv"},     vif.dispense_valid, 0);
    check({tag, "_cv"},     vif.change_valid, 0);
    check({tag, "_busy"},   vif.busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cr;
    int n;
    logic [3:0] a;
    logic [1:0] p;

    vif.coin_valid = 0; vif.amount = 0; vif.select_valid = 0; vif.product_id = 0;
    vif.cancel = 0; vif.dispense_ack = 0; vif.change_ack = 0;
    step(); step();
    reset = 1'b0;
    check_idle_clean("rst");
    check("rst_chg_amt", vif.change_amount, 0);
    check("rst_did", vif.dispense_id, 0);
    check("rst_rej", vif.coin_reject, 0);
    check("rst_ins", vif.insufficient, 0);

    // Idle-state corner cases
    coin(4'd0);
    check("idle_coin0_state", state_dbg, ST_IDLE);
    check("idle_coin0_rej", vif.coin_reject, 0);
    select(2'd1);
    check("idle_sel_ins", vif.insufficient, 1);
    step();
    check("idle_ins_pulse", vif.insufficient, 0);
    cancel_req();
    check("idle_cancel_state", state_dbg, ST_IDLE);
    vif.dispense_ack = 1'b1; vif.change_ack = 1'b1;
    step();
    vif.dispense_ack = 1'b0; vif.change_ack = 1'b0;
    check_idle_clean("stray_ack");

    // 5 + 5, product 1 (price 8), change 2
    coin(4'd5);
    check("t1_credit5", vif.credit, 5);
    check("t1_collect", state_dbg, ST_COLLECT);
    coin(4'd5);
    check("t1_credit10", vif.credit, 10);
    exp_disp_q.push_back(8'd1);
    select(2'd1);
    check("t1_check", state_dbg, ST_CHECK);
    check("t1_busy", vif.busy, 1);
    check("t1_dv_early", vif.dispense_valid, 0);
    step();
    check("t1_dv", vif.dispense_valid, 1);
    check("t1_did", vif.dispense_id, 1);
    check("t1_credit2", vif.credit, 2);
    exp_chg_q.push_back(8'd2);
    ack_dispense();
    check("t1_cv", vif.change_valid, 1);
    check("t1_chg_state", state_dbg, ST_CHANGE);
    check("t1_dv_drop", vif.dispense_valid, 0);
    ack_change();
    check_idle_clean("t1_end");
    check("t1_camt_clr", vif.change_amount, 0);

    // 10 + 5, product 3 (price 15), no change
    coin(4'd10);
    coin(4'd5);
    check("t2_credit15", vif.credit, 15);
    exp_disp_q.push_back(8'd3);
    select(2'd3);
    step();
    check("t2_dv", vif.dispense_valid, 1);
    check("t2_credit0", vif.credit, 0);
    ack_dispense();
    check_idle_clean("t2_end");
    step();
    check("t2_no_cv", vif.change_valid, 0);

    // 4, product 2 refused; +8 then accepted exactly
    coin(4'd4);
    select(2'd2);
    step();
    check("t3_ins", vif.insufficient, 1);
    check("t3_credit4", vif.credit, 4);
    check("t3_collect", state_dbg, ST_COLLECT);
    check("t3_no_dv", vif.dispense_valid, 0);
    coin(4'd8);
    check("t3_ins_pulse", vif.insufficient, 0);
    check("t3_credit12", vif.credit, 12);
    exp_disp_q.push_back(8'd2);
    select(2'd2);
    step();
    check("t3_dv", vif.dispense_valid, 1);
    ack_dispense();
    check_idle_clean("t3_end");

    // Fill to MAX_CREDIT, overflow coin rejected, cancel refunds 60
    for (int i = 0; i < 4; i++) coin(4'd15);
    check("t4_credit60", vif.credit, 60);
    check("t4_rej_none", vif.coin_reject, 0);
    coin(4'd1);
    check("t4_rej", vif.coin_reject, 1);
    check("t4_credit_hold", vif.credit, 60);
    exp_chg_q.push_back(8'd60);
    cancel_req();
    check("t4_cv", vif.change_valid, 1);
    check("t4_camt", vif.change_amount, 60);
    ack_change();
    check_idle_clean("t4_end");

    // Cancel + select + coin together with credit 7
    coin(4'd7);
    exp_chg_q.push_back(8'd7);
    drive(1'b1, 4'd3, 1'b1, 2'd2, 1'b1);
    check("t5_state", state_dbg, ST_CHANGE);
    check("t5_cv", vif.change_valid, 1);
    check("t5_camt", vif.change_amount, 7);
    check("t5_rej", vif.coin_reject, 1);
    coin(4'd2);
    check("t5_chg_rej", vif.coin_reject, 1);
    check("t5_chg_credit", vif.credit, 7);
    ack_change();
    check_idle_clean("t5_end");
    coin(4'd10);
    exp_disp_q.push_back(8'd0);
    select(2'd0);
    step();
    check("t5_disp_credit", vif.credit, 5);
    select(2'd1);
    check("t5_sel_ignored", state_dbg, ST_DISPENSE);
    check("t5_did_stable", vif.dispense_id, 0);
    check("t5_no_ins", vif.insufficient, 0);
    exp_chg_q.push_back(8'd5);
    ack_dispense();
    ack_change();
    check_idle_clean("t5_end2");

    // Reset in the middle of a dispense with credit 3
    coin(4'd8);
    exp_disp_q.push_back(8'd0);
    select(2'd0);
    step();
    check("t6_dv", vif.dispense_valid, 1);
    check("t6_credit3", vif.credit, 3);
    reset = 1'b1;
    exp_disp_q.delete();
    step();
    reset = 1'b0;
    check_idle_clean("t6_rst");
    check("t6_did", vif.dispense_id, 0);
    check("t6_camt", vif.change_amount, 0);
    coin(4'd5);
    check("t6_credit5", vif.credit, 5);
    exp_chg_q.push_back(8'd5);
    cancel_req();
    ack_change();
    check_idle_clean("t6_end");

    // Random purchases checked against a credit model
    for (int it = 0; it < 20; it++) begin
      a = 4'($urandom_range(1, 15));
      cr = a;
      coin(a);
      check("rnd_first", vif.credit, cr);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        a = 4'($urandom_range(0, 15));
        coin(a);
        if (cr + a <= 60) begin
          cr = cr + a;
          check("rnd_rej0", vif.coin_reject, 0);
        end else begin
          check("rnd_rej1", vif.coin_reject, 1);
        end
        check("rnd_credit", vif.credit, cr);
      end
      p = 2'($urandom_range(0, 3));
      if (cr >= price_tab[p]) exp_disp_q.push_back({6'd0, p});
      select(p);
      check("rnd_busy", vif.busy, 1);
      step();
      if (cr >= price_tab[p]) begin
        check("rnd_dv", vif.dispense_valid, 1);
        check("rnd_left", vif.credit, cr - price_tab[p]);
        if (cr > price_tab[p]) exp_chg_q.push_back(8'(cr - price_tab[p]));
        ack_dispense();
        if (cr > price_tab[p]) ack_change();
      end else begin
        check("rnd_ins", vif.insufficient, 1);
        check("rnd_keep", vif.credit, cr);
        exp_chg_q.push_back(8'(cr));
        cancel_req();
        ack_change();
      end
      check_idle_clean("rnd_end");
    end

    step();
    check("disp_q_drained", exp_disp_q.size(), 0);
    check("chg_q_drained", exp_chg_q.size(), 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
Top-level sequencer of the vending machine. Accepts coin events from the money-receive path and accumulates credit. Accepts a product selection, checks credit against a per-product price table, then runs a dispense handshake and a change-return handshake. Sits between the money-receive module, the selection keypad and the dispenser/coin-return actuators.

Parameters:
CREDIT_W, 8, width of the credit accumulator and change output
MAX_CREDIT, 60, highest credit accepted; a coin that would exceed it is rejected
PRICE0, 5, price of product 0
PRICE1, 8, price of product 1
PRICE2, 12, price of product 2
PRICE3, 15, price of product 3

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
coin_valid  input  1  one-cycle pulse, a coin of value amount is presented
amount  input  4  coin value 0..15, sampled when coin_valid=1
select_valid  input  1  one-cycle pulse, product selection presented
product_id  input  2  selected product, sampled when select_valid=1
cancel  input  1  one-cycle pulse, customer requests refund
dispense_ack  input  1  dispenser has taken the current request
change_ack  input  1  coin-return has paid out change_amount
credit  output  CREDIT_W  current accumulated credit (registered)
coin_reject  output  1  one-cycle pulse, the coin presented was refused
insufficient  output  1  one-cycle pulse, selection refused for lack of credit
dispense_valid  output  1  dispense request, held until acknowledged
dispense_id  output  2  product to dispense, stable while dispense_valid=1
change_valid  output  1  change request, held until acknowledged
change_amount  output  CREDIT_W  change to return, stable while change_valid=1
busy  output  1  high in CHECK, DISPENSE and CHANGE

Behaviour:
- The clock and reset are as declared above: one clock; reset is synchronous and active-high.
- Reset, sampled on the rising edge, overrides everything:
  - state goes to IDLE
  - credit=0
  - all pulses, valids, dispense_id and change_amount go to 0
  - reset mid-dispense or mid-change aborts the transaction and discards the credit.
- All outputs are registered. Pulses last exactly one cycle.
- States: IDLE, COLLECT, CHECK, DISPENSE, CHANGE.
- IDLE:
  - coin_valid with amount!=0 loads credit=amount, next state COLLECT.
  - coin_valid with amount=0 is ignored (no reject pulse).
  - select_valid in IDLE produces an insufficient pulse.
  - cancel in IDLE is ignored.
- COLLECT: priority is cancel > select_valid > coin_valid when inputs coincide.
  - cancel, with credit>0: go to CHANGE.
  - select_valid: latch product_id, go to CHECK. A coin in the same cycle is rejected.
  - coin_valid: if credit+amount <= MAX_CREDIT, credit += amount on the next edge. Otherwise pulse coin_reject and leave credit unchanged. The sum is computed CREDIT_W+1 bits wide, so it cannot wrap.
- CHECK (exactly 1 cycle):
  - If credit >= price[id]: credit -= price, load dispense_id, assert dispense_valid on the next edge, go to DISPENSE.
  - Otherwise: pulse insufficient, return to COLLECT with credit unchanged.
- DISPENSE: dispense_valid stays high until a cycle with dispense_ack=1. On that edge dispense_valid drops, then:
  - if credit>0: load change_amount=credit, assert change_valid, go to CHANGE
  - if credit=0: go to IDLE.
- CHANGE:
  - Entered from cancel: change_amount=credit and change_valid rise on the edge leaving COLLECT.
  - Hold change_valid until change_ack=1. On that edge: change_valid=0, credit=0, change_amount=0, go to IDLE.
- coin_valid in CHECK, DISPENSE or CHANGE gives a coin_reject pulse and no credit change.
- select_valid and cancel in those states are ignored.
- An ack arriving while the corresponding valid is low is ignored.
- Latency:
  - Selection to dispense_valid is 2 cycles: select sampled, CHECK, then dispense_valid high.
  - Cancel to change_valid is 1 cycle.

Test Plan:
- Reset; coins 5, 5 then select 1 → credit goes 5 then 10; dispense_valid=1 with id=1 two cycles after select; ack → change_valid=1, change_amount=2; ack → credit=0, IDLE.
- Coins 10, 5 then select 3 (price 15) → dispense id=3; after dispense_ack goes directly to IDLE with change_valid never asserted.
- Coin 4 then select 2 (price 12) → insufficient pulse, credit stays 4, state COLLECT; coin 8 then select 2 → dispense, no change.
- Coins 15,15,15,15 (credit 60) then coin 1 → coin_reject pulse, credit stays 60; cancel → change_amount=60 one cycle later.
- Cancel, select and coin in the same cycle with credit 7 → CHANGE with change_amount=7, coin_reject pulse; then a coin during CHANGE → reject; select during DISPENSE → ignored.
- Reset asserted while dispense_valid=1 with credit 3 → next cycle all outputs 0, credit=0, state IDLE; a subsequent coin 5 gives credit=5.
